sdram_axi_burst_sched: RTL and testbench
========================================

Name: sdram_axi_burst_sched

Overview:
- Upstream traffic sequencer for the SDRAM+AXI top level.
- After SDRAM init completes and on a start pulse, it issues NUM_BURSTS interleaved write/read burst pairs.
- It drives the shared burst address, the write/read burst enables and read_valid.
- It judges completion of each burst from the FIFO fill counts, with a per-burst watchdog, and reports busy/done/error to the system controller.

Parameters:
- BASE_ADDR, 23'd0, first burst address.
- BURST_LEN, 16, words per burst; address step between bursts.
- NUM_BURSTS, 8, write/read pairs per run (1..255).
- GAP_CYC, 4, idle cycles after each completed burst (0 allowed).
- TIMEOUT_CYC, 4096, maximum cycles in any wait state before error.

Ports:
- sys_clk  in  1  single clock.
- sys_rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  run request, sampled on the rising edge; ignored while busy.
- init_end  in  1  SDRAM initialisation complete.
- wr_fifo_num  in  10  write FIFO fill level.
- rd_fifo_num  in  10  read FIFO fill level.
- addr  out  23  current burst address, shared by write and read.
- i_write_burst_en  out  1  one-cycle write burst request.
- i_read_burst_en  out  1  one-cycle read burst request.
- read_valid  out  1  SDRAM read enable; high from RD_REQ through RD_WAIT.
- busy  out  1  run in progress.
- done  out  1  sticky: run finished without error.
- timeout_err  out  1  sticky: watchdog expired.
- burst_idx  out  8  index of the current pair, 0-based.

Behaviour:
- Reset values: addr=BASE_ADDR, i_write_burst_en=0, i_read_burst_en=0, read_valid=0, busy=0, done=0, timeout_err=0, burst_idx=0, state=IDLE.
- All outputs are registered.
- States: IDLE, WAIT_INIT, WR_REQ, WR_WAIT, WR_GAP, RD_REQ, RD_WAIT, RD_GAP, DONE, ERR.
- IDLE/DONE/ERR + start:
  - Clear done and timeout_err.
  - Load addr=BASE_ADDR and burst_idx=0.
  - Set busy=1.
  - Go to WR_REQ if init_end=1, else WAIT_INIT.
- WAIT_INIT: stay until init_end=1, then go to WR_REQ. The watchdog is not active here.
- WR_REQ: i_write_burst_en=1 for exactly this one cycle; clear the seen_nz flag; go to WR_WAIT.
- WR_WAIT:
  - seen_nz is set when wr_fifo_num!=0.
  - Completion = seen_nz && wr_fifo_num==0, evaluated on the registered flag (the earliest completion is one cycle after the first nonzero sample).
  - On completion go to WR_GAP.
- WR_GAP: wait GAP_CYC cycles (GAP_CYC=0 means 1 transit cycle), then go to RD_REQ.
- RD_REQ: i_read_burst_en=1 for one cycle; read_valid goes to 1; clear seen_nz; go to RD_WAIT.
- RD_WAIT: same completion rule on rd_fifo_num. On completion read_valid returns to 0 and the block goes to RD_GAP.
- RD_GAP: wait GAP_CYC cycles, then:
  - If burst_idx==NUM_BURSTS-1: go to DONE with busy=0, done=1.
  - Else: burst_idx+1, addr = (addr+BURST_LEN) mod 2^23 (wraps silently), go to WR_REQ.
- addr is stable from WR_REQ through the end of RD_GAP of the same pair.
- Watchdog:
  - The counter resets on entry to WR_WAIT/RD_WAIT.
  - At count == TIMEOUT_CYC-1 without completion: go to ERR with timeout_err=1, busy=0, read_valid=0, and enables=0.
  - addr and burst_idx hold the failing pair.
- Simultaneous completion and timeout in the same cycle: completion wins.
- init_end falling mid-run: no state change; the watchdog catches any stall.
- start while busy: ignored, with no effect on counters.
- Asynchronous reset mid-run: all outputs return to their reset values immediately; no further enables are issued.

Test Plan:
- Defaults, init_end=1, start pulse; FIFO model rises to 16 then drains to 0 after each enable -> 8 write/read pairs in order, addr 0,16,...,112; done=1, busy=0, exactly 8 pulses of each enable.
- start with init_end=0 for 50 cycles -> no enables while init_end=0; first i_write_burst_en 1 cycle after init_end rises.
- TIMEOUT_CYC=64; rd_fifo_num held at 0 after the 3rd read request -> timeout_err=1 after 64 cycles; burst_idx=2, addr=32, read_valid=0, busy=0.
- BASE_ADDR=23'h7FFFF8, NUM_BURSTS=2 -> second pair uses addr=23'h000008 (wrap); done=1.
- start pulsed during RD_WAIT of pair 1 -> ignored, run still completes 8 pairs; a new start in DONE restarts from BASE_ADDR and clears done.
- sys_rst_n asserted during WR_WAIT of pair 4 -> all outputs at reset values asynchronously; after release the block stays IDLE until start.

Source files
------------

// File: rtl/sdram_axi_burst_sched_if.sv
// Burst request and FIFO fill-level bundle between the traffic sequencer
// and the SDRAM+AXI datapath.
interface sdram_axi_burst_sched_if;
   logic [22:0] addr;
   logic        i_write_burst_en;
   logic        i_read_burst_en;
   logic        read_valid;
   logic [9:0]  wr_fifo_num;
   logic [9:0]  rd_fifo_num;

   modport master (
      output addr, i_write_burst_en, i_read_burst_en, read_valid,
      input  wr_fifo_num, rd_fifo_num
   );

   modport slave (
      input  addr, i_write_burst_en, i_read_burst_en, read_valid,
      output wr_fifo_num, rd_fifo_num
   );
endinterface

// File: rtl/sdram_axi_burst_sched.sv
// Upstream traffic sequencer: after SDRAM init, issues NUM_BURSTS write/read
// burst pairs, judges completion from FIFO fill levels, with a per-burst watchdog.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | out of reset, waiting for start
// WAIT_INIT | run requested, waiting for SDRAM init_end
// WR_REQ    | one-cycle write burst request
// WR_WAIT   | waiting for write FIFO to fill then drain (watchdog armed)
// WR_GAP    | idle gap after write burst
// RD_REQ    | one-cycle read burst request, read_valid raised
// RD_WAIT   | waiting for read FIFO to fill then drain (watchdog armed)
// RD_GAP    | idle gap after read burst, then next pair or DONE
// DONE      | run finished cleanly, restartable
// ERR       | watchdog expired, restartable
module sdram_axi_burst_sched #(
   parameter logic [22:0] BASE_ADDR   = 23'd0,
   parameter int          BURST_LEN   = 16,
   parameter int          NUM_BURSTS  = 8,
   parameter int          GAP_CYC     = 4,
   parameter int          TIMEOUT_CYC = 4096
) (
   input  logic                            sys_clk,
   input  logic                            sys_rst_n,
   input  logic                            start,
   input  logic                            init_end,
   sdram_axi_burst_sched_if.master         bus,
   output logic                            busy,
   output logic                            done,
   output logic                            timeout_err,
   output logic [7:0]                      burst_idx
);

   localparam int TMAX = (TIMEOUT_CYC > GAP_CYC) ? TIMEOUT_CYC : GAP_CYC;
   localparam int TW   = (TMAX > 2) ? $clog2(TMAX) : 1;
   localparam logic [TW-1:0] TO_LOAD  = TW'(TIMEOUT_CYC - 1);
   localparam logic [TW-1:0] GAP_LOAD = TW'((GAP_CYC == 0) ? 0 : GAP_CYC - 1);
   localparam logic [7:0]    LAST_IDX = 8'(NUM_BURSTS - 1);

   typedef enum logic [3:0] {
      S_IDLE, S_WAIT_INIT, S_WR_REQ, S_WR_WAIT, S_WR_GAP,
      S_RD_REQ, S_RD_WAIT, S_RD_GAP, S_DONE, S_ERR
   } state_t;

   state_t        state_q, state_d;
   logic [22:0]   addr_q, addr_d;
   logic [7:0]    idx_q, idx_d;
   logic [TW-1:0] tmr_q, tmr_d;
   logic          wr_en_q, wr_en_d;
   logic          rd_en_q, rd_en_d;
   logic          rvld_q, rvld_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          err_q, err_d;
   logic          seen_nz_q, seen_nz_d;
   logic [9:0]    fifo_num;
   logic          burst_cmpl;

   assign fifo_num   = (state_q == S_RD_WAIT) ? bus.rd_fifo_num : bus.wr_fifo_num;
   assign burst_cmpl = seen_nz_q && (fifo_num == 10'd0);

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      idx_d     = idx_q;
      tmr_d     = tmr_q;
      wr_en_d   = 1'b0;
      rd_en_d   = 1'b0;
      rvld_d    = rvld_q;
      busy_d    = busy_q;
      done_d    = done_q;
      err_d     = err_q;
      seen_nz_d = seen_nz_q;
      case (state_q)
         S_IDLE, S_DONE, S_ERR: begin
            if (start) begin
               done_d = 1'b0;
               err_d  = 1'b0;
               addr_d = BASE_ADDR;
               idx_d  = 8'd0;
               busy_d = 1'b1;
               if (init_end) begin
                  state_d = S_WR_REQ;
                  wr_en_d = 1'b1;
               end else begin
                  state_d = S_WAIT_INIT;
               end
            end
         end
         S_WAIT_INIT: begin
            if (init_end) begin
               state_d = S_WR_REQ;
               wr_en_d = 1'b1;
            end
         end
         S_WR_REQ, S_RD_REQ: begin
            seen_nz_d = 1'b0;
            tmr_d     = TO_LOAD;
            state_d   = (state_q == S_WR_REQ) ? S_WR_WAIT : S_RD_WAIT;
         end
         S_WR_WAIT, S_RD_WAIT: begin
            seen_nz_d = seen_nz_q | (fifo_num != 10'd0);
            // completion is checked before the watchdog so it wins a tie
            if (burst_cmpl) begin
               tmr_d   = GAP_LOAD;
               rvld_d  = 1'b0;
               state_d = (state_q == S_WR_WAIT) ? S_WR_GAP : S_RD_GAP;
            end else if (tmr_q == '0) begin
               state_d = S_ERR;
               err_d   = 1'b1;
               busy_d  = 1'b0;
               rvld_d  = 1'b0;
            end else begin
               tmr_d = tmr_q - TW'(1);
            end
         end
         S_WR_GAP: begin
            if (tmr_q == '0) begin
               state_d = S_RD_REQ;
               rd_en_d = 1'b1;
               rvld_d  = 1'b1;
            end else begin
               tmr_d = tmr_q - TW'(1);
            end
         end
         S_RD_GAP: begin
            if (tmr_q != '0) begin
               tmr_d = tmr_q - TW'(1);
            end else if (idx_q == LAST_IDX) begin
               state_d = S_DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end else begin
               idx_d   = idx_q + 8'd1;
               addr_d  = addr_q + 23'(BURST_LEN);
               state_d = S_WR_REQ;
               wr_en_d = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q   <= S_IDLE;
         addr_q    <= BASE_ADDR;
         idx_q     <= 8'd0;
         tmr_q     <= '0;
         wr_en_q   <= 1'b0;
         rd_en_q   <= 1'b0;
         rvld_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         seen_nz_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         idx_q     <= idx_d;
         tmr_q     <= tmr_d;
         wr_en_q   <= wr_en_d;
         rd_en_q   <= rd_en_d;
         rvld_q    <= rvld_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         err_q     <= err_d;
         seen_nz_q <= seen_nz_d;
      end
   end

   assign bus.addr             = addr_q;
   assign bus.i_write_burst_en = wr_en_q;
   assign bus.i_read_burst_en  = rd_en_q;
   assign bus.read_valid       = rvld_q;
   assign busy                 = busy_q;
   assign done                 = done_q;
   assign timeout_err          = err_q;
   assign burst_idx            = idx_q;

endmodule

// File: tb/tb_sdram_axi_burst_sched.sv
// Bench for the burst sequencer: three configurations driven by a FIFO
// fill/drain responder, checked against an arithmetic model of the burst sequence.
module tb_sdram_axi_burst_sched;
   localparam int LEN = 16;

   logic             sys_clk = 1'b0;
   logic             sys_rst_n;
   logic             init_end;
   logic [2:0]       start_v;
   logic [2:0]       we, re, rvl, busy_o, done_o, err_o;
   logic [2:0][7:0]  idx_o;
   logic [2:0][22:0] addr_o;
   logic [9:0]       wn [3] = '{default: 10'd0};
   logic [9:0]       rn [3] = '{default: 10'd0};

   // responder / monitor state
   int          cyc = 0;
   int          mode [3] = '{default: 0};
   int          lvl [3] = '{default: 0};
   int          dly [3] = '{default: 0};
   int          tgt [3] = '{default: 0};
   int          rd_cnt [3] = '{default: 0};
   int          dbl [3] = '{default: 0};
   int          prev_en [3] = '{default: 0};
   int          stall_at [3];
   logic [32:0] evq [3][$];
   int          tsq [3][$];
   int          endq [3][$];

   int n_cmp, n_err;

   sdram_axi_burst_sched_if b0 ();
   sdram_axi_burst_sched_if b1 ();
   sdram_axi_burst_sched_if b2 ();

   sdram_axi_burst_sched u0 (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start_v[0]), .init_end(init_end),
      .bus(b0.master), .busy(busy_o[0]), .done(done_o[0]), .timeout_err(err_o[0]),
      .burst_idx(idx_o[0]));

   sdram_axi_burst_sched #(.TIMEOUT_CYC(64)) u1 (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start_v[1]), .init_end(init_end),
      .bus(b1.master), .busy(busy_o[1]), .done(done_o[1]), .timeout_err(err_o[1]),
      .burst_idx(idx_o[1]));

   sdram_axi_burst_sched #(.BASE_ADDR(23'h7FFFF8), .NUM_BURSTS(2), .GAP_CYC(0)) u2 (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start_v[2]), .init_end(init_end),
      .bus(b2.master), .busy(busy_o[2]), .done(done_o[2]), .timeout_err(err_o[2]),
      .burst_idx(idx_o[2]));

   assign b0.wr_fifo_num = wn[0];
   assign b0.rd_fifo_num = rn[0];
   assign b1.wr_fifo_num = wn[1];
   assign b1.rd_fifo_num = rn[1];
   assign b2.wr_fifo_num = wn[2];
   assign b2.rd_fifo_num = rn[2];
   assign we[0] = b0.i_write_burst_en;
   assign we[1] = b1.i_write_burst_en;
   assign we[2] = b2.i_write_burst_en;
   assign re[0] = b0.i_read_burst_en;
   assign re[1] = b1.i_read_burst_en;
   assign re[2] = b2.i_read_burst_en;
   assign rvl[0] = b0.read_valid;
   assign rvl[1] = b1.read_valid;
   assign rvl[2] = b2.read_valid;
   assign addr_o[0] = b0.addr;
   assign addr_o[1] = b1.addr;
   assign addr_o[2] = b2.addr;

   always #5 sys_clk = ~sys_clk;

   // FIFO behaviour: after a request, a random delay, then fill 1..16 and drain to 0
   always @(negedge sys_clk) begin
      cyc++;
      for (int g = 0; g < 3; g++) begin
         if (!sys_rst_n) begin
            mode[g] = 0; lvl[g] = 0; rd_cnt[g] = 0; prev_en[g] = 0;
         end else begin
            if (we[g] || re[g]) begin
               evq[g].push_back({rvl[g], re[g], idx_o[g], addr_o[g]});
               tsq[g].push_back(cyc);
               if (prev_en[g] != 0) dbl[g]++;
            end
            prev_en[g] = (we[g] || re[g]) ? 1 : 0;
            case (mode[g])
               0: begin
                  if (we[g]) begin
                     tgt[g] = 0; mode[g] = 1; dly[g] = $urandom_range(1, 3);
                  end else if (re[g]) begin
                     rd_cnt[g]++;
                     if (rd_cnt[g] != stall_at[g]) begin
                        tgt[g] = 1; mode[g] = 1; dly[g] = $urandom_range(1, 3);
                     end
                  end
               end
               1: begin
                  dly[g]--;
                  if (dly[g] == 0) mode[g] = 2;
               end
               2: begin
                  lvl[g]++;
                  if (lvl[g] == LEN) mode[g] = 3;
               end
               default: begin
                  lvl[g]--;
                  if (lvl[g] == 0) begin
                     mode[g] = 0;
                     endq[g].push_back(cyc);
                  end
               end
            endcase
         end
         wn[g] = (tgt[g] == 0) ? 10'(lvl[g]) : 10'd0;
         rn[g] = (tgt[g] == 1) ? 10'(lvl[g]) : 10'd0;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(negedge sys_clk);
         #1;
      end
   endtask

   task automatic pulse_start(input int g);
      start_v[g] = 1'b1;
      tick(1);
      start_v[g] = 1'b0;
   endtask

   // expected run: W0 R0 W1 R1 ..., addr = (base + k*LEN) mod 2^23, gap = max(GAP,1)+1
   task automatic check_run(input int g, input int first, input int n, input int base,
                            input int gdelta);
      for (int k = 0; k < n; k++) begin
         for (int r = 0; r < 2; r++) begin
            int          j;
            int          a;
            logic [32:0] e;
            logic [32:0] o;
            j = first + 2 * k + r;
            a = (base + k * LEN) % (1 << 23);
            e = {r[0], r[0], k[7:0], a[22:0]};
            o = (j < evq[g].size()) ? evq[g][j] : 'x;
            chk($sformatf("u%0d_ev%0d", g, j), 64'(o), 64'(e));
            if (j > first) begin
               int d;
               d = (j < tsq[g].size() && j - 1 < endq[g].size()) ?
                   tsq[g][j] - endq[g][j - 1] : -1;
               chk($sformatf("u%0d_gap%0d", g, j), 64'(d), 64'(gdelta));
            end
         end
      end
      chk($sformatf("u%0d_ev_count", g), 64'(evq[g].size() - first), 64'(2 * n));
   endtask

   initial begin
      int pulsed;
      int n0;
      int t_r;
      n_cmp = 0;
      n_err = 0;
      stall_at = '{0, 0, 0};
      start_v = 3'b000;
      init_end = 1'b1;
      sys_rst_n = 1'b0;
      tick(3);
      chk("rst_addr0", 64'(addr_o[0]), 64'(0));
      chk("rst_addr2", 64'(addr_o[2]), 64'(23'h7FFFF8));
      chk("rst_en", 64'({we, re, rvl}), 64'(0));
      chk("rst_status", 64'({busy_o, done_o, err_o}), 64'(0));
      chk("rst_idx0", 64'(idx_o[0]), 64'(0));
      sys_rst_n = 1'b1;
      tick(2);
      chk("idle_busy", 64'(busy_o), 64'(0));

      // normal run, with a start pulse in RD_WAIT of pair 1
      pulse_start(0);
      chk("u0_busy", 64'(busy_o[0]), 64'(1));
      pulsed = 0;
      for (int i = 0; i < 3000 && !done_o[0]; i++) begin
         tick(1);
         if (pulsed == 0 && evq[0].size() == 4) begin
            tick(1);
            pulse_start(0);
            pulsed = 1;
            chk("u0_start_ignored_busy", 64'(busy_o[0]), 64'(1));
            chk("u0_start_ignored_idx", 64'(idx_o[0]), 64'(1));
         end
      end
      chk("u0_done", 64'(done_o[0]), 64'(1));
      chk("u0_busy_end", 64'(busy_o[0]), 64'(0));
      chk("u0_err", 64'(err_o[0]), 64'(0));
      chk("u0_rvld_end", 64'(rvl[0]), 64'(0));
      chk("u0_idx_end", 64'(idx_o[0]), 64'(7));
      chk("u0_addr_end", 64'(addr_o[0]), 64'(112));
      tick(10);
      check_run(0, 0, 8, 0, 5);

      // watchdog: 3rd read never fills
      stall_at[1] = 3;
      pulse_start(1);
      for (int i = 0; i < 2000 && evq[1].size() < 6; i++) tick(1);
      chk("u1_r2_issued", 64'(evq[1].size()), 64'(6));
      t_r = (evq[1].size() >= 6) ? tsq[1][5] : 0;
      for (int i = 0; i < 200 && !err_o[1]; i++) tick(1);
      chk("u1_err", 64'(err_o[1]), 64'(1));
      chk("u1_to_cycles", 64'(cyc - t_r), 64'(65));
      chk("u1_idx", 64'(idx_o[1]), 64'(2));
      chk("u1_addr", 64'(addr_o[1]), 64'(32));
      chk("u1_rvld", 64'(rvl[1]), 64'(0));
      chk("u1_busy_done", 64'({busy_o[1], done_o[1]}), 64'(0));
      tick(5);
      check_run(1, 0, 3, 0, 5);

      // address wrap, zero gap
      pulse_start(2);
      for (int i = 0; i < 1000 && !done_o[2]; i++) tick(1);
      chk("u2_done", 64'(done_o[2]), 64'(1));
      chk("u2_addr_end", 64'(addr_o[2]), 64'(23'h000008));
      tick(5);
      check_run(2, 0, 2, 23'h7FFFF8, 2);

      // restart from DONE with init pending
      init_end = 1'b0;
      pulse_start(0);
      chk("u0_restart_done_clr", 64'(done_o[0]), 64'(0));
      chk("u0_restart_busy", 64'(busy_o[0]), 64'(1));
      chk("u0_restart_addr", 64'(addr_o[0]), 64'(0));
      chk("u0_restart_idx", 64'(idx_o[0]), 64'(0));
      n0 = evq[0].size();
      tick(49);
      chk("u0_no_en_wo_init", 64'(evq[0].size()), 64'(n0));
      init_end = 1'b1;
      tick(1);
      chk("u0_wr_after_init", 64'(we[0]), 64'(1));
      for (int i = 0; i < 3000 && !done_o[0]; i++) tick(1);
      chk("u0_done2", 64'(done_o[0]), 64'(1));
      tick(10);
      check_run(0, 16, 8, 0, 5);

      // asynchronous reset in WR_WAIT of pair 4
      pulse_start(0);
      for (int i = 0; i < 3000 && !(evq[0].size() >= 41 && wn[0] != 10'd0); i++) tick(1);
      chk("u0_pair4", 64'(idx_o[0]), 64'(4));
      sys_rst_n = 1'b0;
      #1;
      chk("arst_addr", 64'(addr_o[0]), 64'(0));
      chk("arst_idx", 64'(idx_o[0]), 64'(0));
      chk("arst_flags", 64'({we[0], re[0], rvl[0], busy_o[0], done_o[0], err_o[0]}), 64'(0));
      tick(3);
      sys_rst_n = 1'b1;
      n0 = evq[0].size();
      tick(20);
      chk("arst_no_en", 64'(evq[0].size()), 64'(n0));
      chk("arst_idle", 64'({busy_o[0], done_o[0], err_o[0]}), 64'(0));
      chk("dbl_pulses", 64'(dbl[0] + dbl[1] + dbl[2]), 64'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
